lsram_fwft_fifo_ctrl: RTL and testbench



---
 rtl/lsram_fifo_pkg.sv | 19 +
 rtl/fwft_out_stage.sv | 61 ++++++
 rtl/lsram_fwft_fifo_ctrl.sv | 119 +++++++++++
 tb/tb_lsram_fwft_fifo_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsram_fifo_pkg.sv
// Shared constants and helpers for the LSRAM-backed FWFT FIFO controller.
//   DEF_WIDTH / DEF_AWIDTH : default RAM word and address widths (1024 x 40)
//   depth_of()             : number of RAM words for a given address width
//   cnt_width()            : width of the total-occupancy counter
package lsram_fifo_pkg;

   localparam int unsigned DEF_WIDTH  = 40;
   localparam int unsigned DEF_AWIDTH = 10;

   function automatic int unsigned depth_of(input int unsigned awidth);
      return 32'd1 << awidth;
   endfunction

   // Occupancy spans 0..DEPTH+2 (RAM plus two output slots), so two bits past the address.
   function automatic int unsigned cnt_width(input int unsigned awidth);
      return awidth + 2;
   endfunction

endpackage

// File: rtl/fwft_out_stage.sv
// Two-entry output skid stage (head register plus hold register) for the FWFT FIFO.
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : synchronous clear of occupancy (a word landing this cycle is dropped)
//   load, data : word arriving from the RAM read port this cycle
//   pop        : head consumed this cycle (only asserted while occ > 0)
//   occ        : number of valid entries (0..2)
//   head       : oldest entry, drives the stream output directly
module fwft_out_stage #(
   parameter int unsigned WIDTH = 40
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             load,
   input  logic [WIDTH-1:0] data,
   input  logic             pop,
   output logic [1:0]       occ,
   output logic [WIDTH-1:0] head
);

   logic [WIDTH-1:0] hold_q;
   logic [WIDTH-1:0] head_d;
   logic [WIDTH-1:0] hold_d;
   logic [1:0]       occ_left;
   logic [1:0]       occ_d;

   always_comb begin
      head_d   = head;
      hold_d   = hold_q;
      occ_left = occ - {1'b0, pop};
      // Only shift when the hold slot is live, so head stays put on the last pop.
      if (pop && occ == 2'd2) begin
         head_d = hold_q;
      end
      // Landing word takes the first free slot after the shift; prefetch never overfills.
      if (load) begin
         if (occ_left == 2'd0) begin
            head_d = data;
         end else begin
            hold_d = data;
         end
      end
      occ_d = occ_left + {1'b0, load};
      if (flush) begin
         occ_d = 2'd0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occ    <= 2'd0;
         head   <= '0;
         hold_q <= '0;
      end else begin
         occ    <= occ_d;
         head   <= head_d;
         hold_q <= hold_d;
      end
   end

endmodule

// File: rtl/lsram_fwft_fifo_ctrl.sv
// First-word-fall-through FIFO controller sequencing an external two-port LSRAM
// (one write port, one read port, 1-cycle read latency, unregistered output).
//   CLK, RESET_N          : clock, asynchronous active-low reset
//   FLUSH                 : synchronous clear; blocks push and prefetch while high
//   S_DATA/S_VALID/S_READY: write stream
//   M_DATA/M_VALID/M_READY: read stream, M_DATA registered
//   W_DATA/W_ADDR/W_EN    : RAM write port
//   R_ADDR/R_EN/R_DATA    : RAM read port, R_DATA valid the cycle after R_EN
//   COUNT                 : total words held (RAM + in-flight read + output stage)
//   ALMOST_FULL/EMPTY     : registered threshold flags on COUNT
module lsram_fwft_fifo_ctrl
   import lsram_fifo_pkg::*;
#(
   parameter int unsigned WIDTH     = DEF_WIDTH,
   parameter int unsigned AWIDTH    = DEF_AWIDTH,
   parameter int unsigned AFULL_TH  = 1000,
   parameter int unsigned AEMPTY_TH = 4
) (
   input  logic                         CLK,
   input  logic                         RESET_N,
   input  logic                         FLUSH,
   input  logic [WIDTH-1:0]             S_DATA,
   input  logic                         S_VALID,
   output logic                         S_READY,
   output logic [WIDTH-1:0]             M_DATA,
   output logic                         M_VALID,
   input  logic                         M_READY,
   output logic [WIDTH-1:0]             W_DATA,
   output logic [AWIDTH-1:0]            W_ADDR,
   output logic                         W_EN,
   output logic [AWIDTH-1:0]            R_ADDR,
   output logic                         R_EN,
   input  logic [WIDTH-1:0]             R_DATA,
   output logic [cnt_width(AWIDTH)-1:0] COUNT,
   output logic                         ALMOST_FULL,
   output logic                         ALMOST_EMPTY
);

   localparam int unsigned     DEPTH    = depth_of(AWIDTH);
   localparam int unsigned     CW       = cnt_width(AWIDTH);
   localparam logic [AWIDTH:0] RAM_FULL = (AWIDTH + 1)'(DEPTH);

   logic [AWIDTH-1:0] wr_ptr_q;
   logic [AWIDTH-1:0] rd_ptr_q;
   logic [AWIDTH:0]   ram_cnt_q;
   logic [AWIDTH:0]   ram_cnt_d;
   logic              inflight_q;
   logic [1:0]        occ;
   logic [2:0]        slots_used;
   logic [CW-1:0]     count_d;
   logic              push;
   logic              pop;
   logic              r_en;

   always_comb begin
      S_READY    = (ram_cnt_q < RAM_FULL) && !FLUSH;
      push       = S_VALID && S_READY;
      M_VALID    = (occ != 2'd0);
      pop        = M_VALID && M_READY;
      // Output slots already claimed: landed words plus the read still in flight.
      slots_used = {1'b0, occ} + {2'b0, inflight_q};
      r_en       = (ram_cnt_q != '0) && (slots_used < (3'd2 + {2'b0, pop})) && !FLUSH;
      ram_cnt_d  = ram_cnt_q + {{AWIDTH{1'b0}}, push} - {{AWIDTH{1'b0}}, r_en};
      // Prefetch only moves words between stages, so the total changes by push - pop.
      count_d    = FLUSH ? '0 : (COUNT + CW'(push) - CW'(pop));
   end

   assign W_EN   = push;
   assign W_ADDR = wr_ptr_q;
   assign W_DATA = S_DATA;
   assign R_EN   = r_en;
   assign R_ADDR = rd_ptr_q;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         ram_cnt_q    <= '0;
         inflight_q   <= 1'b0;
         COUNT        <= '0;
         ALMOST_FULL  <= 1'b0;
         ALMOST_EMPTY <= 1'b1;
      end else begin
         if (FLUSH) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ram_cnt_q  <= '0;
            inflight_q <= 1'b0;
         end else begin
            if (push) begin
               wr_ptr_q <= wr_ptr_q + AWIDTH'(1);
            end
            if (r_en) begin
               rd_ptr_q <= rd_ptr_q + AWIDTH'(1);
            end
            ram_cnt_q  <= ram_cnt_d;
            inflight_q <= r_en;
         end
         COUNT        <= count_d;
         ALMOST_FULL  <= (count_d >= CW'(AFULL_TH));
         ALMOST_EMPTY <= (count_d <= CW'(AEMPTY_TH));
      end
   end

   // The read issued last cycle lands now; FLUSH inside the stage drops it.
   fwft_out_stage #(
      .WIDTH (WIDTH)
   ) u_out_stage (
      .clk   (CLK),
      .rst_n (RESET_N),
      .flush (FLUSH),
      .load  (inflight_q),
      .data  (R_DATA),
      .pop   (pop),
      .occ   (occ),
      .head  (M_DATA)
   );

endmodule

// File: tb/tb_lsram_fwft_fifo_ctrl.sv
module tb_lsram_fwft_fifo_ctrl;

   localparam int W  = 40;
   localparam int AW = 10;

   logic          CLK = 1'b0;
   logic          RESET_N;
   logic          FLUSH;
   logic [W-1:0]  S_DATA;
   logic          S_VALID;
   logic          S_READY;
   logic [W-1:0]  M_DATA;
   logic          M_VALID;
   logic          M_READY;
   logic [W-1:0]  W_DATA;
   logic [AW-1:0] W_ADDR;
   logic          W_EN;
   logic [AW-1:0] R_ADDR;
   logic          R_EN;
   logic [W-1:0]  R_DATA;
   logic [AW+1:0] COUNT;
   logic          ALMOST_FULL;
   logic          ALMOST_EMPTY;

   int n_checks = 0;
   int n_bad    = 0;
   bit mon_en   = 1'b0;
   logic [W-1:0] sb[$];
   logic [W-1:0] mem[1024];

   always #5 CLK = ~CLK;

   lsram_fwft_fifo_ctrl dut (
      .CLK          (CLK),
      .RESET_N      (RESET_N),
      .FLUSH        (FLUSH),
      .S_DATA       (S_DATA),
      .S_VALID      (S_VALID),
      .S_READY      (S_READY),
      .M_DATA       (M_DATA),
      .M_VALID      (M_VALID),
      .M_READY      (M_READY),
      .W_DATA       (W_DATA),
      .W_ADDR       (W_ADDR),
      .W_EN         (W_EN),
      .R_ADDR       (R_ADDR),
      .R_EN         (R_EN),
      .R_DATA       (R_DATA),
      .COUNT        (COUNT),
      .ALMOST_FULL  (ALMOST_FULL),
      .ALMOST_EMPTY (ALMOST_EMPTY)
   );

   // RAM model: registered read, one cycle latency.
   always @(posedge CLK) begin
      if (W_EN) mem[W_ADDR] <= W_DATA;
      if (R_EN) R_DATA <= mem[R_ADDR];
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic next();
      @(posedge CLK);
      #1;
   endtask

   task automatic sample();
      @(negedge CLK);
   endtask

   // Scoreboard: COUNT/flags against the reference occupancy, pops against push order.
   always @(negedge CLK) begin
      if (!RESET_N) begin
         sb.delete();
      end else if (mon_en) begin
         check("count", COUNT, sb.size());
         check("almost_full", ALMOST_FULL, sb.size() >= 1000);
         check("almost_empty", ALMOST_EMPTY, sb.size() <= 4);
         if (FLUSH) begin
            sb.delete();
         end else begin
            if (M_VALID && M_READY) begin
               if (sb.size() == 0) check("pop_nonempty", 0, 1);
               else check("m_data", M_DATA, sb.pop_front());
            end
            if (S_VALID && S_READY) sb.push_back(S_DATA);
         end
      end
   end

   task automatic drain();
      bit done;
      done    = 1'b0;
      S_VALID = 1'b0;
      M_READY = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         sample();
         if (COUNT == 0 && !M_VALID) begin
            done = 1'b1;
            break;
         end
         next();
      end
      check("drain_done", done, 1);
      next();
      M_READY = 1'b0;
   endtask

   task automatic wait_valid(input string tag);
      for (int i = 0; i < 10; i++) begin
         sample();
         if (M_VALID) break;
         next();
      end
      check(tag, M_VALID, 1);
   endtask

   task automatic push_words(input int n, input logic [7:0] tag);
      M_READY = 1'b0;
      for (int i = 0; i < n; i++) begin
         S_VALID = 1'b1;
         S_DATA  = {tag, 32'(i)};
         next();
      end
      S_VALID = 1'b0;
   endtask

   initial begin
      int sent;
      int cyc;
      RESET_N = 1'b0;
      FLUSH   = 1'b0;
      S_VALID = 1'b0;
      S_DATA  = '0;
      M_READY = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      RESET_N = 1'b1;
      mon_en  = 1'b1;

      // Reset state
      sample();
      check("rst_s_ready", S_READY, 1);
      check("rst_m_valid", M_VALID, 0);
      check("rst_count", COUNT, 0);
      check("rst_aempty", ALMOST_EMPTY, 1);
      check("rst_afull", ALMOST_FULL, 0);
      check("rst_w_en", W_EN, 0);
      check("rst_r_en", R_EN, 0);
      check("rst_m_data", M_DATA, 0);
      next();

      // Single word latency: push k, R_EN k+1, M_VALID k+3
      S_VALID = 1'b1;
      S_DATA  = 40'h12_3456_789A;
      sample();
      check("k_w_en", W_EN, 1);
      check("k_w_addr", W_ADDR, 0);
      check("k_r_en", R_EN, 0);
      next();
      S_VALID = 1'b0;
      sample();
      check("k1_r_en", R_EN, 1);
      check("k1_r_addr", R_ADDR, 0);
      next();
      sample();
      check("k2_m_valid", M_VALID, 0);
      next();
      sample();
      check("k3_m_valid", M_VALID, 1);
      check("k3_m_data", M_DATA, 40'h12_3456_789A);
      check("k3_count", COUNT, 1);
      next();
      M_READY = 1'b1;
      next();
      M_READY = 1'b0;
      sample();
      check("k5_count", COUNT, 0);
      check("k5_m_valid", M_VALID, 0);
      next();

      // Fill to DEPTH+2 with no pops; write pointer starts at 1 after the single word
      for (int i = 0; i < 1026; i++) begin
         S_VALID = 1'b1;
         S_DATA  = 40'(i);
         sample();
         check("fill_s_ready", S_READY, 1);
         if (i == 1022) check("w_addr_top", W_ADDR, 1023);
         if (i == 1023) check("w_addr_wrap", W_ADDR, 0);
         next();
      end
      S_DATA = 40'hFF_FFFF_FFFF;
      sample();
      check("full_s_ready", S_READY, 0);
      check("full_w_en", W_EN, 0);
      next();
      S_VALID = 1'b0;
      sample();
      check("full_count", COUNT, 1026);
      check("full_afull", ALMOST_FULL, 1);
      next();
      // One pop at full: prefetch refills immediately, S_READY returns next cycle
      M_READY = 1'b1;
      sample();
      check("full_pop_r_en", R_EN, 1);
      next();
      M_READY = 1'b0;
      sample();
      check("full_pop_s_ready", S_READY, 1);
      next();
      drain();

      // Sustained one word per cycle after a 10-word preload
      push_words(10, 8'hC0);
      repeat (4) next();
      for (int j = 0; j < 3000; j++) begin
         S_VALID = 1'b1;
         M_READY = 1'b1;
         S_DATA  = {8'hD0, 32'(j)};
         sample();
         check("stream_m_valid", M_VALID, 1);
         check("stream_s_ready", S_READY, 1);
         next();
      end
      drain();

      // Random handshakes, 10000 words
      sent = 0;
      cyc  = 0;
      while (sent < 10000 && cyc < 60000) begin
         S_VALID = 1'($urandom_range(0, 1));
         M_READY = 1'($urandom_range(0, 1));
         S_DATA  = {8'(sent), 32'($urandom)};
         sample();
         if (S_VALID && S_READY) sent++;
         next();
         cyc++;
      end
      check("rand_sent", sent, 10000);
      drain();

      // Flush while the read issued alongside the last pop is still in flight
      push_words(5, 8'hE0);
      repeat (5) next();
      M_READY = 1'b1;
      sample();
      check("pre_flush_r_en", R_EN, 1);
      next();
      M_READY = 1'b0;
      FLUSH   = 1'b1;
      S_VALID = 1'b1;
      S_DATA  = 40'hBB;
      sample();
      check("flush_s_ready", S_READY, 0);
      check("flush_w_en", W_EN, 0);
      check("flush_r_en", R_EN, 0);
      next();
      FLUSH   = 1'b0;
      S_VALID = 1'b0;
      sample();
      check("post_flush_count", COUNT, 0);
      check("post_flush_m_valid", M_VALID, 0);
      next();
      S_VALID = 1'b1;
      S_DATA  = 40'hAA;
      next();
      S_VALID = 1'b0;
      wait_valid("flush_aa_valid");
      check("flush_aa_first", M_DATA, 40'hAA);
      next();
      drain();

      // Asynchronous reset mid-operation
      push_words(3, 8'hF0);
      repeat (2) next();
      RESET_N = 1'b0;
      #1;
      check("arst_count", COUNT, 0);
      check("arst_m_valid", M_VALID, 0);
      check("arst_r_en", R_EN, 0);
      next();
      RESET_N = 1'b1;
      S_VALID = 1'b1;
      S_DATA  = 40'h77;
      next();
      S_VALID = 1'b0;
      wait_valid("arst_77_valid");
      check("arst_77_first", M_DATA, 40'h77);
      next();
      drain();

      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule
